// File: rtl/hsv_pipe_ctrl.sv
// Stage-enable / valid-bit sequencer and per-frame pixel counter for the RGB->HSV pipeline.
// Optional feature: define HSV_PIPE_CTRL_STALL_CNT_EN to add the saturating stall_cnt output.
module hsv_pipe_ctrl #(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned CNT_W      = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      frame_len,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic [CNT_W-1:0]      pix_out_cnt
`ifdef HSV_PIPE_CTRL_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    logic [NUM_STAGES-1:0] r_valid;
    logic [CNT_W-1:0]      r_len;
    logic [CNT_W-1:0]      r_in_cnt;
    logic [CNT_W-1:0]      r_out_cnt;

    logic                  w_advance;
    logic                  w_in_ready;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic [CNT_W-1:0]      w_in_cnt_nxt;
    logic [CNT_W-1:0]      w_out_cnt_nxt;

    // Abort outranks every handshake, so it masks acceptance, enables and result counting.
    assign w_advance     = ~r_valid[NUM_STAGES-1] | out_ready;
    assign w_in_ready    = (r_state == S_RUN) & w_advance & (r_in_cnt != r_len) & ~abort;
    assign w_in_fire     = in_valid & w_in_ready;
    assign w_out_fire    = r_valid[NUM_STAGES-1] & out_ready & ~abort;
    assign w_in_cnt_nxt  = r_in_cnt + CNT_W'(1);
    assign w_out_cnt_nxt = r_out_cnt + CNT_W'(1);

    assign in_ready    = w_in_ready;
    assign out_valid   = r_valid[NUM_STAGES-1];
    assign busy        = (r_state == S_RUN) | (r_state == S_DRAIN);
    assign frame_done  = (r_state == S_DONE);
    assign pix_out_cnt = r_out_cnt;

    assign stage_en[0]              = w_in_fire;
    assign stage_en[NUM_STAGES-1:1] = {(NUM_STAGES-1){w_advance & ~abort}} & r_valid[NUM_STAGES-2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_valid   <= '0;
            r_len     <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_valid <= '0;
        end else begin
            if (w_advance)
                r_valid <= {r_valid[NUM_STAGES-2:0], w_in_fire};
            if (w_out_fire)
                r_out_cnt <= w_out_cnt_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len     <= frame_len;
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                        r_state   <= (frame_len == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_in_fire) begin
                        r_in_cnt <= w_in_cnt_nxt;
                        if (w_in_cnt_nxt == r_len)
                            r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_out_fire && (w_out_cnt_nxt == r_len))
                        r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef HSV_PIPE_CTRL_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!abort) begin
            if ((r_state == S_IDLE) && start)
                r_stall_cnt <= '0;
            else if (busy && r_valid[NUM_STAGES-1] && !out_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hsv_pipe_ctrl.sv
// Randomized, self-checking bench for hsv_pipe_ctrl against a queue-based transaction model.
// Honours HSV_PIPE_CTRL_STALL_CNT_EN when defined.
module tb_hsv_pipe_ctrl;

    localparam int unsigned NS      = 4;
    localparam int unsigned CW      = 8;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;
`ifdef HSV_PIPE_CTRL_STALL_CNT_EN
    localparam int unsigned VW = 4 + NS + 2 * CW;
`else
    localparam int unsigned VW = 4 + NS + CW;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] frame_len = '0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic [NS-1:0] stage_en;
    logic          out_valid;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] pix_out_cnt;
`ifdef HSV_PIPE_CTRL_STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    hsv_pipe_ctrl #(.NUM_STAGES(NS), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .frame_len   (frame_len),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .stage_en    (stage_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .frame_done  (frame_done),
        .pix_out_cnt (pix_out_cnt)
`ifdef HSV_PIPE_CTRL_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    logic [VW-1:0] obs;
    logic [VW-1:0] exp_v;
    assign obs = {in_ready, stage_en, out_valid, busy, frame_done, pix_out_cnt
`ifdef HSV_PIPE_CTRL_STALL_CNT_EN
                  , stall_cnt
`endif
                 };

    int total = 0;
    int bad   = 0;

    // Model: each in-flight pixel is tracked by how many advancing cycles it has survived;
    // it is presented to the sink once that number reaches NS.
    int          q[$];
    int          m_state;
    int unsigned m_len, m_in, m_out, m_stall;
    bit          m_ov, m_adv, m_ir;

    function automatic void model_reset();
        q.delete();
        m_state = M_IDLE;
        m_len = 0; m_in = 0; m_out = 0; m_stall = 0;
    endfunction

    function automatic void predict();
        logic [NS-1:0] se;
        m_ov  = (q.size() > 0) && (q[0] == NS);
        m_adv = !m_ov || out_ready;
        m_ir  = (m_state == M_RUN) && m_adv && (m_in != m_len) && !abort;
        se    = '0;
        se[0] = in_valid && m_ir;
        foreach (q[j])
            if (q[j] >= 1 && q[j] < NS && m_adv && !abort) se[q[j]] = 1'b1;
        exp_v = {m_ir, se, m_ov, (m_state == M_RUN) || (m_state == M_DRAIN), m_state == M_DONE, CW'(m_out)
`ifdef HSV_PIPE_CTRL_STALL_CNT_EN
                 , CW'(m_stall)
`endif
                };
    endfunction

    task automatic drive(input logic st, input logic [CW-1:0] fl, input logic ab,
                         input logic iv, input logic ordy);
        start = st; frame_len = fl; abort = ab; in_valid = iv; out_ready = ordy;
        @(negedge clk);
        predict();
    endtask

    task automatic commit();
        bit fo, fi;
        if (abort) begin
            q.delete();
            m_state = M_IDLE;
        end else begin
            fo = m_ov && out_ready;
            fi = in_valid && m_ir;
            if ((m_state == M_RUN || m_state == M_DRAIN) && m_ov && !out_ready && m_stall != CNT_MAX)
                m_stall++;
            if (m_adv) begin
                if (fo) void'(q.pop_front());
                foreach (q[j]) q[j]++;
                if (fi) q.push_back(1);
            end
            if (fo) m_out = (m_out + 1) & CNT_MAX;
            case (m_state)
                M_IDLE: if (start) begin
                    m_len = frame_len; m_in = 0; m_out = 0; m_stall = 0;
                    m_state = (frame_len == 0) ? M_DONE : M_RUN;
                end
                M_RUN: if (fi) begin
                    m_in = (m_in + 1) & CNT_MAX;
                    if (m_in == m_len) m_state = M_DRAIN;
                end
                M_DRAIN: if (fo && m_out == m_len) m_state = M_DONE;
                default: m_state = M_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", obs);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int n_ir = 0, n_se0 = 0, ov_first = -1, ov_last = -1, fd_cyc = -1, n_fd = 0;
        for (int k = 0; k <= 16; k++) begin
            drive(k == 0, CW'(8), 1'b0, 1'b1, 1'b1);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL basic_cycle k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if (in_ready) n_ir++;
            if (stage_en[0]) n_se0++;
            if (out_valid) begin
                if (ov_first < 0) ov_first = k;
                ov_last = k;
            end
            if (frame_done) begin n_fd++; fd_cyc = k; end
            commit();
        end
        total++;
        if (n_ir != 8 || n_se0 != 8) begin
            bad++;
            $display("FAIL basic_in_count in_ready=%0d stage_en0=%0d want 8/8", n_ir, n_se0);
        end
        total++;
        if (ov_first != 5 || ov_last != 12) begin
            bad++;
            $display("FAIL basic_out_window got=%0d..%0d want=5..12", ov_first, ov_last);
        end
        total++;
        if (n_fd != 1 || fd_cyc != 13 || pix_out_cnt !== CW'(8)) begin
            bad++;
            $display("FAIL basic_done n=%0d cyc=%0d cnt=%0d want 1/13/8", n_fd, fd_cyc, pix_out_cnt);
        end
    endtask

    task automatic test_stall();
        int hold = 0, nfire = 0;
        bit held = 0;
        logic r;
        for (int k = 0; k < 20; k++) begin
            r = 1'b1;
            if (!held && out_valid === 1'b1) begin held = 1; hold = 3; end
            if (hold > 0) begin r = 1'b0; hold--; end
            drive(k == 0, CW'(4), 1'b0, 1'b1, r);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL stall_cycle k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if (!r) begin
                total++;
                if (stage_en !== '0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_freeze k=%0d stage_en=%b in_ready=%b out_valid=%b want 0/0/1",
                             k, stage_en, in_ready, out_valid);
                end
            end
            if (out_valid && out_ready) nfire++;
            commit();
        end
        total++;
        if (nfire != 4 || pix_out_cnt !== CW'(4)) begin
            bad++;
            $display("FAIL stall_results fires=%0d cnt=%0d want 4/4", nfire, pix_out_cnt);
        end
    endtask

    task automatic test_bubbles();
        int nfire = 0, sixth = -1, fd_cyc = -1, n_fd = 0;
        for (int k = 0; k < 22; k++) begin
            drive(k == 0, CW'(6), 1'b0, (k % 2) == 1, 1'b1);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL bubble_cycle k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if (out_valid && out_ready) begin
                nfire++;
                if (nfire == 6) sixth = k;
            end
            if (frame_done) begin n_fd++; fd_cyc = k; end
            commit();
        end
        total++;
        if (nfire != 6 || n_fd != 1 || fd_cyc != sixth + 1) begin
            bad++;
            $display("FAIL bubble_beats beats=%0d done=%0d@%0d sixth@%0d want 6/1/sixth+1",
                     nfire, n_fd, fd_cyc, sixth);
        end
    endtask

    task automatic test_zero_len();
        int n_ir = 0, n_fd = 0, fd_cyc = -1, n_busy = 0;
        for (int k = 0; k < 5; k++) begin
            drive(k == 0, CW'(0), 1'b0, 1'b1, 1'b1);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL zero_cycle k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if (in_ready) n_ir++;
            if (busy) n_busy++;
            if (frame_done) begin n_fd++; fd_cyc = k; end
            commit();
        end
        total++;
        if (n_ir != 0 || n_busy != 0 || n_fd != 1 || fd_cyc != 1) begin
            bad++;
            $display("FAIL zero_len ready=%0d busy=%0d done=%0d@%0d want 0/0/1@1", n_ir, n_busy, n_fd, fd_cyc);
        end
    endtask

    task automatic test_abort();
        int nfire = 0, n_fd = 0, abort_k = -1;
        bit ab;
        for (int k = 0; k < 10; k++) begin
            ab = (nfire == 3) && (abort_k < 0);
            if (ab) abort_k = k;
            drive(k == 0, CW'(10), ab, abort_k < 0, !ab);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL abort_cycle k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if (abort_k >= 0 && k == abort_k + 1) begin
                total++;
                if (out_valid !== 1'b0 || busy !== 1'b0 || stage_en !== '0 || in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL abort_flush ov=%b busy=%b se=%b ir=%b want all 0",
                             out_valid, busy, stage_en, in_ready);
                end
            end
            if (in_valid && in_ready) nfire++;
            if (frame_done) n_fd++;
            commit();
        end
        total++;
        if (n_fd != 0 || abort_k != 4) begin
            bad++;
            $display("FAIL abort_nodone done=%0d abort_at=%0d want 0/4", n_fd, abort_k);
        end
        for (int k = 0; k < 10; k++) begin
            drive(k == 0, CW'(2), 1'b0, 1'b1, 1'b1);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL abort_restart k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if (frame_done) n_fd++;
            commit();
        end
        total++;
        if (n_fd != 1 || pix_out_cnt !== CW'(2)) begin
            bad++;
            $display("FAIL abort_next_frame done=%0d cnt=%0d want 1/2", n_fd, pix_out_cnt);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            int unsigned len;
            int n_in = 0;
            bit done = 0;
            len = $urandom_range(1, 12);
            for (int k = 0; k < 300 && !done; k++) begin
                drive((k == 0) || ($urandom_range(0, 7) == 0),
                      (k == 0) ? CW'(len) : CW'($urandom_range(0, 255)), 1'b0,
                      $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
                total++;
                if (obs !== exp_v) begin
                    bad++;
                    $display("FAIL random_cycle f=%0d k=%0d got=%h want=%h", f, k, obs, exp_v);
                end
                if (in_valid && in_ready) n_in++;
                if (frame_done) done = 1;
                commit();
            end
            total++;
            if (!done || n_in != int'(len)) begin
                bad++;
                $display("FAIL random_frame f=%0d done=%0d accepted=%0d want 1/%0d", f, done, n_in, len);
            end
        end
    endtask

    task automatic test_max_len();
        bit done = 0;
        logic [CW-1:0] cnt_at_done = '0;
        for (int k = 0; k < 300 && !done; k++) begin
            drive(k == 0, '1, 1'b0, 1'b1, 1'b1);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL maxlen_cycle k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if (frame_done) begin done = 1; cnt_at_done = pix_out_cnt; end
            commit();
        end
        total++;
        if (!done || cnt_at_done !== CW'(CNT_MAX)) begin
            bad++;
            $display("FAIL maxlen_done done=%0d cnt=%0d want 1/%0d", done, cnt_at_done, CNT_MAX);
        end
    endtask

    task automatic test_async_reset();
        int n_in = 0, n_fd = 0;
        bit reached = 0;
        for (int k = 0; k < 20 && !reached; k++) begin
            drive((k == 0) || (k == 2), (k == 0) ? CW'(5) : CW'(1), 1'b0, 1'b1, 1'b1);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL areset_cycle k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if (in_valid && in_ready) n_in++;
            commit();
            if (m_state == M_DRAIN) reached = 1;
        end
        total++;
        if (!reached || n_in != 5) begin
            bad++;
            $display("FAIL start_ignored reached_drain=%0d accepted=%0d want 1/5", reached, n_in);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL areset_outputs got=%h want=0", obs);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
            if (frame_done) n_fd++;
            commit();
        end
        total++;
        if (n_fd != 0) begin
            bad++;
            $display("FAIL areset_nodone done=%0d want 0", n_fd);
        end
    endtask

    initial begin
        model_reset();
        #3;
        test_reset();
        test_basic();
        test_stall();
        test_bubbles();
        test_zero_len();
        test_abort();
        test_random();
        test_max_len();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
